// File: rtl/vz_upload_reader.sv
// Serves a VZ snapshot (24-byte header + RAM bytes) to HPS ioctl_rd requests during an upload session.
// Header bytes return one cycle after ioctl_rd; RAM bytes return the cycle after mem_ack or the timeout.
module vz_upload_reader #(
  parameter logic [127:0] FILE_NAME   = {80'd0, "MISTER"},
  parameter int unsigned  MEM_TIMEOUT = 255
) (
  input  logic        i_clk_sys,
  input  logic        i_reset,
  input  logic        i_ioctl_upload,
  input  logic        i_ioctl_rd,
  input  logic [15:0] i_ioctl_addr,
  output logic [7:0]  o_ioctl_din,
  output logic        o_ioctl_wait,
  input  logic [15:0] i_prog_start,
  input  logic [15:0] i_prog_end,
  input  logic        i_prog_type,
  output logic [16:0] o_upload_len,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic [7:0]  i_mem_data,
  input  logic        i_mem_ack,
  output logic        o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HDR, S_MREQ, S_DONE} state_t;

  function automatic int name_len(input logic [127:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (s[8*i +: 8] != 8'h00) n = i + 1;
    return n;
  endfunction

  // Name left-justified so character k sits in byte (15-k) with NUL padding below it.
  localparam int NAME_LEN = name_len(FILE_NAME);
  localparam logic [127:0] NAME_LJ = FILE_NAME << (8 * (16 - NAME_LEN));

  state_t      r_state, w_next;
  logic [15:0] r_start;
  logic        r_type;
  logic [16:0] r_len;
  logic [7:0]  r_din;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_cnt;
  logic        r_abort;

  logic        w_rd_ok, w_in_data, w_timeout, w_discard;
  logic [16:0] w_data_len;
  logic [3:0]  w_k;
  logic [7:0]  w_hdr_byte;

  assign w_rd_ok    = (r_state == S_ARMED) & i_ioctl_upload & i_ioctl_rd;
  assign w_in_data  = ({1'b0, i_ioctl_addr} >= 17'd24) & ({1'b0, i_ioctl_addr} < r_len);
  assign w_timeout  = (r_cnt == 8'(MEM_TIMEOUT - 1));
  assign w_discard  = r_abort | ~i_ioctl_upload;
  assign w_data_len = (i_prog_end >= i_prog_start) ?
                      ({1'b0, i_prog_end} - {1'b0, i_prog_start} + 17'd1) : 17'd0;
  assign w_k        = i_ioctl_addr[3:0] - 4'd4;

  always_comb begin
    w_hdr_byte = 8'h00;
    if (i_ioctl_addr < 16'd24) begin
      case (i_ioctl_addr[4:0])
        5'd0:    w_hdr_byte = 8'h56;
        5'd1:    w_hdr_byte = 8'h5A;
        5'd2:    w_hdr_byte = 8'h46;
        5'd3:    w_hdr_byte = 8'h30;
        5'd21:   w_hdr_byte = {7'b1111000, r_type};
        5'd22:   w_hdr_byte = r_start[7:0];
        5'd23:   w_hdr_byte = r_start[15:8];
        default: w_hdr_byte = (i_ioctl_addr[4:0] < 5'd20) ? NAME_LJ[{~w_k, 3'b000} +: 8] : 8'h00;
      endcase
    end
  end

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_ioctl_upload) w_next = S_ARMED;
      S_ARMED: begin
        if (!i_ioctl_upload) w_next = S_IDLE;
        else if (i_ioctl_rd) w_next = w_in_data ? S_MREQ : S_HDR;
      end
      S_HDR:   w_next = i_ioctl_upload ? S_ARMED : S_IDLE;
      // The RAM handshake is always completed, even when the session is gone.
      S_MREQ:  if (i_mem_ack | w_timeout) w_next = w_discard ? S_IDLE : S_DONE;
      S_DONE:  w_next = i_ioctl_upload ? S_ARMED : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req    = (r_state == S_MREQ);
    o_busy       = (r_state != S_IDLE);
    o_ioctl_wait = ((r_state == S_MREQ) & i_ioctl_upload) | (i_ioctl_rd & (r_state == S_ARMED));
    o_ioctl_din  = r_din;
    o_mem_addr   = r_mem_addr;
    o_upload_len = r_len;
  end

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_start    <= 16'h0000;
      r_type     <= 1'b0;
      r_len      <= 17'd24;
      r_din      <= 8'h00;
      r_mem_addr <= 16'h0000;
      r_cnt      <= 8'h00;
      r_abort    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_ioctl_upload) begin
          r_start <= i_prog_start;
          r_type  <= i_prog_type;
          r_len   <= 17'd24 + w_data_len;
          r_abort <= 1'b0;
        end
        S_ARMED: if (w_rd_ok) begin
          if (w_in_data) begin
            r_mem_addr <= r_start + i_ioctl_addr - 16'd24;
            r_cnt      <= 8'h00;
            r_abort    <= 1'b0;
          end else begin
            r_din <= w_hdr_byte;
          end
        end
        S_MREQ: begin
          r_cnt <= r_cnt + 8'h01;
          if (!i_ioctl_upload) r_abort <= 1'b1;
          if (i_mem_ack && !w_discard)      r_din <= i_mem_data;
          else if (w_timeout && !i_mem_ack && !w_discard) r_din <= 8'hFF;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vz_upload_reader.sv
// Scoreboard bench for vz_upload_reader: "HELLO" name, 4-cycle memory timeout.
module tb_vz_upload_reader;
  logic        i_clk_sys = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_ioctl_upload = 1'b0;
  logic        i_ioctl_rd = 1'b0;
  logic [15:0] i_ioctl_addr = 16'h0000;
  logic [15:0] i_prog_start = 16'h0000;
  logic [15:0] i_prog_end = 16'h0000;
  logic        i_prog_type = 1'b0;
  logic [7:0]  i_mem_data = 8'h00;
  logic        i_mem_ack = 1'b0;
  logic [7:0]  o_ioctl_din;
  logic        o_ioctl_wait;
  logic [16:0] o_upload_len;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        o_busy;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_din = 8'h00;

  always #5 i_clk_sys = ~i_clk_sys;

  vz_upload_reader #(.FILE_NAME({88'd0, "HELLO"}), .MEM_TIMEOUT(4)) dut (
    .i_clk_sys(i_clk_sys), .i_reset(i_reset), .i_ioctl_upload(i_ioctl_upload),
    .i_ioctl_rd(i_ioctl_rd), .i_ioctl_addr(i_ioctl_addr), .o_ioctl_din(o_ioctl_din),
    .o_ioctl_wait(o_ioctl_wait), .i_prog_start(i_prog_start), .i_prog_end(i_prog_end),
    .i_prog_type(i_prog_type), .o_upload_len(o_upload_len), .o_mem_req(o_mem_req),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data), .i_mem_ack(i_mem_ack), .o_busy(o_busy)
  );

  task automatic start_session(input logic [15:0] s, input logic [15:0] e, input logic t,
                               input logic [16:0] exp_len);
    @(negedge i_clk_sys);
    i_ioctl_upload = 1'b0;
    i_prog_start = s; i_prog_end = e; i_prog_type = t;
    @(negedge i_clk_sys);
    i_ioctl_upload = 1'b1;
    @(negedge i_clk_sys);
    n_vec++;
    if (o_upload_len !== exp_len) begin
      n_err++; $display("FAIL upload_len got %0d want %0d", o_upload_len, exp_len);
    end
    n_vec++;
    if (o_busy !== 1'b1) begin
      n_err++; $display("FAIL busy_session got %b want 1", o_busy);
    end
  endtask

  // ack_dly = 0 means the memory never acknowledges.
  task automatic rd_byte(input logic [15:0] a, input int ack_dly, input logic [7:0] md,
                         input logic [15:0] exp_addr, input int exp_reqs, input logic [7:0] exp_din);
    int reqs, lat;
    bit got;
    logic [7:0] e;
    @(negedge i_clk_sys);
    i_ioctl_addr = a; i_ioctl_rd = 1'b1;
    #1;
    n_vec++;
    if (o_ioctl_wait !== 1'b1) begin
      n_err++; $display("FAIL rd_%0h_wait_same_cycle got %b want 1", a, o_ioctl_wait);
    end
    exp_q.push_back(exp_din);
    @(negedge i_clk_sys);
    i_ioctl_rd = 1'b0;
    reqs = 0; lat = 1; got = 0;
    while (!got && lat < 40) begin
      if (!o_ioctl_wait && !o_mem_req) got = 1;
      else begin
        if (o_mem_req) begin
          reqs++;
          if (reqs == 1) begin
            n_vec++;
            if (o_mem_addr !== exp_addr) begin
              n_err++; $display("FAIL rd_%0h_mem_addr got %h want %h", a, o_mem_addr, exp_addr);
            end
          end
          if (ack_dly != 0 && reqs == ack_dly) begin
            i_mem_ack = 1'b1; i_mem_data = md;
          end
        end
        @(negedge i_clk_sys);
        i_mem_ack = 1'b0; i_mem_data = 8'h00;
        lat++;
      end
    end
    e = exp_q.pop_front();
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL rd_%0h_no_response got wait=%b want wait low within 40 cycles", a, o_ioctl_wait);
    end else begin
      if (o_ioctl_din !== e) begin
        n_err++; $display("FAIL rd_%0h_din got %h want %h", a, o_ioctl_din, e);
      end
      n_vec++;
      if (lat != exp_reqs + 1) begin
        n_err++; $display("FAIL rd_%0h_latency got %0d want %0d", a, lat, exp_reqs + 1);
      end
      n_vec++;
      if (reqs != exp_reqs) begin
        n_err++; $display("FAIL rd_%0h_req_cycles got %0d want %0d", a, reqs, exp_reqs);
      end
      last_din = o_ioctl_din;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk_sys);
    n_vec++; if (o_ioctl_din !== 8'h00) begin n_err++; $display("FAIL reset_din got %h want 00", o_ioctl_din); end
    n_vec++; if (o_ioctl_wait !== 1'b0) begin n_err++; $display("FAIL reset_wait got %b want 0", o_ioctl_wait); end
    n_vec++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", o_mem_req); end
    n_vec++; if (o_mem_addr !== 16'h0000) begin n_err++; $display("FAIL reset_mem_addr got %h want 0000", o_mem_addr); end
    n_vec++; if (o_upload_len !== 17'd24) begin n_err++; $display("FAIL reset_upload_len got %0d want 24", o_upload_len); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", o_busy); end
    i_reset = 1'b0;
  endtask

  task automatic test_header();
    logic [191:0] hv;
    hv = 192'h565A4630_48454C4C4F_000000000000000000000000_F1_0080;
    start_session(16'h8000, 16'h800F, 1'b1, 17'd40);
    for (int i = 0; i < 24; i++) rd_byte(16'(i), 0, 8'h00, 16'h0000, 0, hv[8*(23-i) +: 8]);
    @(negedge i_clk_sys);
    n_vec++;
    if (o_ioctl_din !== last_din) begin
      n_err++; $display("FAIL din_hold got %h want %h", o_ioctl_din, last_din);
    end
  endtask

  task automatic test_mem_read();
    i_prog_start = 16'h1111;
    rd_byte(16'd24, 3, 8'hA5, 16'h8000, 3, 8'hA5);
    rd_byte(16'd39, 2, 8'h3C, 16'h800F, 2, 8'h3C);
    rd_byte(16'd40, 0, 8'h00, 16'h0000, 0, 8'h00);
  endtask

  task automatic test_empty();
    start_session(16'h8000, 16'h7FFF, 1'b0, 17'd24);
    rd_byte(16'd24, 1, 8'hEE, 16'h0000, 0, 8'h00);
    rd_byte(16'd21, 0, 8'h00, 16'h0000, 0, 8'hF0);
  endtask

  task automatic test_wrap();
    start_session(16'hFFFF, 16'hFFFF, 1'b0, 17'd25);
    rd_byte(16'd24, 1, 8'h11, 16'hFFFF, 1, 8'h11);
    rd_byte(16'd25, 1, 8'h22, 16'h0000, 0, 8'h00);
    rd_byte(16'd23, 0, 8'h00, 16'h0000, 0, 8'hFF);
  endtask

  task automatic test_timeout();
    start_session(16'h1234, 16'h1300, 1'b1, 17'd229);
    rd_byte(16'd26, 0, 8'h00, 16'h1236, 4, 8'hFF);
    rd_byte(16'd0, 0, 8'h00, 16'h0000, 0, 8'h56);
  endtask

  task automatic test_abort();
    logic [7:0] held;
    start_session(16'h9000, 16'h90FF, 1'b0, 17'd280);
    held = last_din;
    @(negedge i_clk_sys);
    i_ioctl_addr = 16'd30; i_ioctl_rd = 1'b1;
    @(negedge i_clk_sys);
    i_ioctl_rd = 1'b0;
    n_vec++; if (o_mem_addr !== 16'h9006) begin n_err++; $display("FAIL abort_mem_addr got %h want 9006", o_mem_addr); end
    @(negedge i_clk_sys);
    i_ioctl_upload = 1'b0;
    #1;
    n_vec++; if (o_ioctl_wait !== 1'b0) begin n_err++; $display("FAIL abort_wait_drop got %b want 0", o_ioctl_wait); end
    n_vec++; if (o_mem_req !== 1'b1) begin n_err++; $display("FAIL abort_req_held1 got %b want 1", o_mem_req); end
    @(negedge i_clk_sys);
    n_vec++; if (o_mem_req !== 1'b1) begin n_err++; $display("FAIL abort_req_held2 got %b want 1", o_mem_req); end
    i_mem_ack = 1'b1; i_mem_data = 8'h77;
    @(negedge i_clk_sys);
    i_mem_ack = 1'b0; i_mem_data = 8'h00;
    n_vec++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL abort_req_release got %b want 0", o_mem_req); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", o_busy); end
    n_vec++; if (o_ioctl_din !== held) begin n_err++; $display("FAIL abort_din_discard got %h want %h", o_ioctl_din, held); end
  endtask

  task automatic test_async_reset();
    start_session(16'h4000, 16'h40FF, 1'b1, 17'd280);
    @(negedge i_clk_sys);
    i_ioctl_addr = 16'd24; i_ioctl_rd = 1'b1;
    @(negedge i_clk_sys);
    i_ioctl_rd = 1'b0;
    n_vec++; if (o_mem_req !== 1'b1) begin n_err++; $display("FAIL areset_pre_req got %b want 1", o_mem_req); end
    #2 i_reset = 1'b1;
    #1;
    n_vec++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL areset_mem_req got %b want 0", o_mem_req); end
    n_vec++; if (o_ioctl_wait !== 1'b0) begin n_err++; $display("FAIL areset_wait got %b want 0", o_ioctl_wait); end
    n_vec++; if (o_ioctl_din !== 8'h00) begin n_err++; $display("FAIL areset_din got %h want 00", o_ioctl_din); end
    n_vec++; if (o_mem_addr !== 16'h0000) begin n_err++; $display("FAIL areset_mem_addr got %h want 0000", o_mem_addr); end
    n_vec++; if (o_upload_len !== 17'd24) begin n_err++; $display("FAIL areset_upload_len got %0d want 24", o_upload_len); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL areset_busy got %b want 0", o_busy); end
    i_ioctl_upload = 1'b0;
    @(negedge i_clk_sys);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk_sys);
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL areset_idle_busy got %b want 0", o_busy); end
  endtask

  initial begin
    test_reset();
    test_header();
    test_mem_read();
    test_empty();
    test_wrap();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
endmodule
